wb_write_arbiter: RTL
=====================

// Module: wb_write_arbiter
// PURPOSE
//  Single owner of the register-file write port (rf_wen/rf_wa/rf_wd). Merges in-order
//  pipeline writeback with results from long-latency units (divider, uncached loads),
//  buffering the latter in a small FIFO. Exports a pending-register mask for hazard logic.
//  Register file keeps its same-cycle write bypass, so this block adds no latency on the pipe path.
// PARAMETERS
//  DEPTH        4   long-latency FIFO entries (power of 2, >=2)
//  STARVE_LIMIT 8   consecutive blocked drain cycles before pipe_stall is raised
// PORTS
//  clock       in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-low
//  pipe_wen    in   1   pipeline WB write request (never back-pressured except via pipe_stall)
//  pipe_wa     in   5   pipeline WB destination register
//  pipe_wd     in   32  pipeline WB data
//  lu_valid    in   1   long-latency result valid
//  lu_wa       in   5   long-latency destination register
//  lu_wd       in   32  long-latency data
//  lu_ready    out  1   result accepted when lu_valid && lu_ready
//  rf_wen      out  1   register-file write enable
//  rf_wa       out  5   register-file write address
//  rf_wd       out  32  register-file write data
//  pipe_stall  out  1   registered; pipeline holds WB stage this cycle
//  busy_mask   out  32  bit i = FIFO holds an entry targeting x[i]; bit 0 always 0
//  fifo_count  out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset (reset==0): FIFO empty, starve counter 0, pipe_stall=0, busy_mask=0, fifo_count=0,
//   lu_ready=1, rf_wen=0.
//  pipe_act = pipe_wen && pipe_wa!=0 && !pipe_stall. pipe_wen while pipe_stall=1 is ignored.
//  Port priority per cycle (combinational select, same cycle as inputs):
//   1. pipe_act                    -> rf = pipe (wen=1, wa=pipe_wa, wd=pipe_wd)
//   2. else FIFO non-empty         -> rf = FIFO head; head popped at clock edge
//   3. else lu_valid && lu_wa!=0   -> rf = lu input directly (bypass; no enqueue)
//   4. else rf_wen=0, rf_wa=0, rf_wd=0
//  lu_ready = (fifo_count != DEPTH); depends only on registered state, never on lu_valid.
//  Accepted lu result enqueued at clock edge unless written in case 3 or lu_wa==0 (x0 writes
//   dropped, count unchanged, no busy bit).
//  Full FIFO: simultaneous pop and push legal only if not full at cycle start (lu_ready=0 when full).
//  Simultaneous pop+push: count unchanged, pointers both advance; ordering strictly FIFO.
//  Pointers wrap modulo DEPTH; count distinguishes full from empty.
//  busy_mask: OR over valid entries of (1<<wa), registered-state function; entry popped this
//   cycle still counted this cycle, clears next cycle.
//  WAW: no reordering or squashing here; issue logic must not retire a pipe write to a reg
//   whose busy_mask bit is set or whose long-latency op is outstanding.
//  Starvation: counter increments each cycle FIFO non-empty and pipe_act=1; resets on any pop
//   or empty FIFO. When counter reaches STARVE_LIMIT, pipe_stall=1 for exactly the next
//   cycle (FIFO head drains then), counter cleared. Counter saturates, never wraps.
//  Reset asserted mid-operation: FIFO contents discarded, outputs to reset values immediately.
// TESTING
//  1. Reset: reset=0 -> rf_wen=0, lu_ready=1, busy_mask=0, fifo_count=0, pipe_stall=0.
//  2. Bypass: idle pipe, lu_valid wa=5 wd=0xDEAD -> same cycle rf_wen=1 wa=5 wd=0xDEAD, count 0.
//  3. Collision: pipe wa=3 wd=1 with lu wa=7 wd=2 -> rf writes x3=1; next idle cycle rf writes
//     x7=2; busy_mask=0x80 for one cycle in between.
//  4. Fill: pipe busy every cycle, 5 lu results -> lu_ready=0 after 4th, count=4, 5th held until pop.
//  5. Starvation: pipe busy continuously, 1 queued entry -> pipe_stall=1 on cycle STARVE_LIMIT+1,
//     FIFO head written that cycle, pipe write re-presented next cycle lands.
//  6. x0 and mid-reset: lu wa=0 -> accepted, no rf write, count 0; reset pulse with count=3 -> count 0.

Source files
------------

// File: rtl/wb_write_arbiter_if.sv
// Register-file writeback bus: pipeline and long-latency write sources in,
// the single register-file write port and queue status out.
interface wb_write_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_wen;
    logic [4:0]    pipe_wa;
    logic [31:0]   pipe_wd;
    logic          lu_valid;
    logic [4:0]    lu_wa;
    logic [31:0]   lu_wd;
    logic          lu_ready;
    logic          rf_wen;
    logic [4:0]    rf_wa;
    logic [31:0]   rf_wd;
    logic          pipe_stall;
    logic [31:0]   busy_mask;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  pipe_wen, pipe_wa, pipe_wd, lu_valid, lu_wa, lu_wd,
        output lu_ready, rf_wen, rf_wa, rf_wd, pipe_stall, busy_mask, fifo_count
    );

    modport master (
        output pipe_wen, pipe_wa, pipe_wd, lu_valid, lu_wa, lu_wd,
        input  lu_ready, rf_wen, rf_wa, rf_wd, pipe_stall, busy_mask, fifo_count
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Sole owner of the register-file write port: pipeline writeback first, then queued
// long-latency results, then a direct long-latency bypass when the queue is empty.
module wb_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    wb_write_arbiter_if.slave   io_wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_fifo_wa [DEPTH];
    logic [31:0]   r_fifo_wd [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_stall;

    logic          w_pipe_act;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_bypass;
    logic          w_starve_hit;
    logic [PW-1:0] w_age [DEPTH];
    logic [31:0]   w_busy;
    logic          w_rf_wen;
    logic [4:0]    w_rf_wa;
    logic [31:0]   w_rf_wd;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pipe_act   = io_wb.pipe_wen && (io_wb.pipe_wa != 5'd0) && !r_stall;
    assign w_pop        = !w_empty && !w_pipe_act;
    assign w_bypass     = w_empty && !w_pipe_act && io_wb.lu_valid && (io_wb.lu_wa != 5'd0);
    assign w_push       = io_wb.lu_valid && !w_full && (io_wb.lu_wa != 5'd0) && !w_bypass;
    assign w_starve_hit = !w_empty && w_pipe_act && (r_starve == SW'(STARVE_LIMIT - 1));

    // Distance of each slot from the head; slots closer than r_count hold live entries.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign w_age[g] = PW'(g) - r_rd_ptr;
    end

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, w_age[i]} < r_count) begin
                w_busy = w_busy | (32'd1 << r_fifo_wa[i]);
            end
        end
        w_busy[0] = 1'b0;
    end

    always_comb begin
        w_rf_wen = 1'b0;
        w_rf_wa  = '0;
        w_rf_wd  = '0;
        if (!i_rst_n) begin
            w_rf_wen = 1'b0;
        end else if (w_pipe_act) begin
            w_rf_wen = 1'b1;
            w_rf_wa  = io_wb.pipe_wa;
            w_rf_wd  = io_wb.pipe_wd;
        end else if (!w_empty) begin
            w_rf_wen = 1'b1;
            w_rf_wa  = r_fifo_wa[r_rd_ptr];
            w_rf_wd  = r_fifo_wd[r_rd_ptr];
        end else if (w_bypass) begin
            w_rf_wen = 1'b1;
            w_rf_wa  = io_wb.lu_wa;
            w_rf_wd  = io_wb.lu_wd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_wa[r_wr_ptr] <= io_wb.lu_wa;
            r_fifo_wd[r_wr_ptr] <= io_wb.lu_wd;
        end
    end

    // Starve counter clears on the hit, so it never exceeds STARVE_LIMIT-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_stall <= w_starve_hit;
            if (!w_empty && w_pipe_act && !w_starve_hit) begin
                r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end
        end
    end

    assign io_wb.lu_ready   = !w_full;
    assign io_wb.rf_wen     = w_rf_wen;
    assign io_wb.rf_wa      = w_rf_wa;
    assign io_wb.rf_wd      = w_rf_wd;
    assign io_wb.pipe_stall = r_stall;
    assign io_wb.busy_mask  = w_busy;
    assign io_wb.fifo_count = r_count;
endmodule
